// File: rtl/cam_alloc_pkg.sv
// ---------------------------------------------------------------------------
// cam_alloc_pkg
//   Shared constants and helpers for the cam_alloc entry allocator.
//   - SCRUB_FILL : bit value replicated across DATA to form the default
//                  scrub pattern written into released CAM entries.
//   - ENABLE_ / DISABLE_ : single-bit switch constants.
//   - addr_width(): address width for a given entry count.
// ---------------------------------------------------------------------------
package cam_alloc_pkg;

    localparam logic ENABLE_    = 1'b1;
    localparam logic DISABLE_   = 1'b0;
    localparam logic SCRUB_FILL = ENABLE_;

    // Address width needed to index 'depth' entries (at least 1 bit).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cam_alloc_sel.sv
// ---------------------------------------------------------------------------
// cam_alloc_sel
//   Combinational free-entry search. Scans the free bitmap starting at
//   'start' and wrapping past DEPTH-1 back to 0; the first set bit wins.
//   With start tied to 0 this is a plain lowest-index-first search.
// Ports:
//   free      in  DEPTH  1 = entry is free
//   start     in  ADDR   first index examined
//   sel_addr  out ADDR   chosen entry (0 when nothing is free)
//   sel_found out 1      at least one entry is free
// ---------------------------------------------------------------------------
module cam_alloc_sel
    import cam_alloc_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int ADDR  = addr_width(DEPTH)
) (
    input  logic [DEPTH-1:0] free,
    input  logic [ADDR-1:0]  start,
    output logic [ADDR-1:0]  sel_addr,
    output logic             sel_found
);

    logic [ADDR-1:0] idx;

    always_comb begin
        sel_addr  = '0;
        sel_found = 1'b0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = ADDR'((int'(start) + i) % DEPTH);
            if (!sel_found && free[idx]) begin
                sel_addr  = idx;
                sel_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_alloc.sv
// ---------------------------------------------------------------------------
// cam_alloc
//   Entry allocator and write-port driver for one cam2 write port. Keeps a
//   free-entry bitmap, hands each accepted insert a CAM address, and drives
//   the CAM write one cycle after acceptance. Released entries are
//   overwritten with SCRUB so stale data can never match a lookup.
//
//   Optional feature: define CAM_ALLOC_RR_EN for round-robin entry
//   selection (search starts after the last allocated entry). Without it,
//   the lowest-index free entry is used and no last_alloc register exists.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ins_valid/ins_data/ins_ready   insert request handshake
//   rel_valid/rel_addr             release request (always accepted)
//   we_, wm, wd, waddr             cam2 write port (we_ active-low, wm = 0)
//   alloc_addr        entry given to the most recent insert
//   count, full       allocated-entry count, count == DEPTH
//   rel_err           sticky: an already-free entry was released
//
// Handshake: an insert transfers on a clock edge where ins_valid and
// ins_ready are both high. ins_ready depends only on full and rel_valid,
// never on ins_valid, so the requester may hold ins_valid/ins_data stable
// until it sees the transfer. A release has no ready; it is taken on every
// edge where rel_valid is high and always wins the single write port.
// ---------------------------------------------------------------------------
module cam_alloc
    import cam_alloc_pkg::*;
#(
    parameter int              DATA  = 32,
    parameter int              DEPTH = 32,
    parameter logic [DATA-1:0] SCRUB = {DATA{SCRUB_FILL}},
    localparam int             ADDR  = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ins_valid,
    input  logic [DATA-1:0]   ins_data,
    output logic              ins_ready,
    input  logic              rel_valid,
    input  logic [ADDR-1:0]   rel_addr,
    output logic              we_,
    output logic [DATA-1:0]   wm,
    output logic [DATA-1:0]   wd,
    output logic [ADDR-1:0]   waddr,
    output logic [ADDR-1:0]   alloc_addr,
    output logic [ADDR:0]     count,
    output logic              full,
    output logic              rel_err
);

    localparam logic [ADDR:0] COUNT_ONE  = (ADDR+1)'(1);
    localparam logic [ADDR:0] COUNT_FULL = (ADDR+1)'(DEPTH);

    logic [DEPTH-1:0] free;
    logic [ADDR-1:0]  sel_addr;
    logic             sel_found;
    logic [ADDR-1:0]  sel_start;
    logic             accept;
    logic             rel_hit;

`ifdef CAM_ALLOC_RR_EN
    logic [ADDR-1:0] last_alloc;

    // Start one past the last allocation, wrapping at DEPTH.
    always_comb begin
        sel_start = '0;
        if (int'(last_alloc) != DEPTH - 1) begin
            sel_start = last_alloc + ADDR'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_alloc <= ADDR'(DEPTH - 1);
        end else if (accept) begin
            last_alloc <= sel_addr;
        end
    end
`else
    assign sel_start = '0;
`endif

    cam_alloc_sel #(
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
    ) u_sel (
        .free      (free),
        .start     (sel_start),
        .sel_addr  (sel_addr),
        .sel_found (sel_found)
    );

    assign full      = (count == COUNT_FULL);
    assign ins_ready = !full && !rel_valid;
    assign wm        = '0;

    // sel_found is implied by !full; kept as a guard against bitmap/count skew.
    assign accept  = ins_valid && ins_ready && sel_found;
    assign rel_hit = rel_valid && !free[rel_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            free       <= '1;
            count      <= '0;
            we_        <= 1'b1;
            wd         <= '0;
            waddr      <= '0;
            alloc_addr <= '0;
            rel_err    <= 1'b0;
        end else begin
            we_ <= 1'b1;
            if (rel_valid) begin
                if (rel_hit) begin
                    free[rel_addr] <= 1'b1;
                    count          <= count - COUNT_ONE;
                    we_            <= 1'b0;
                    waddr          <= rel_addr;
                    wd             <= SCRUB;
                end else begin
                    // Releasing a free entry is rejected and remembered.
                    rel_err <= 1'b1;
                end
            end else if (accept) begin
                free[sel_addr] <= 1'b0;
                count          <= count + COUNT_ONE;
                we_            <= 1'b0;
                waddr          <= sel_addr;
                wd             <= ins_data;
                alloc_addr     <= sel_addr;
            end
        end
    end

endmodule

// File: tb/tb_cam_alloc.sv
// ---------------------------------------------------------------------------
// tb_cam_alloc
//   Directed plus randomized bench for cam_alloc. A set-based reference
//   model tracks which entries are allocated and predicts every write.
// ---------------------------------------------------------------------------
module tb_cam_alloc;

    localparam int DATA  = 32;
    localparam int DEPTH = 32;
    localparam int ADDR  = 5;
    localparam logic [DATA-1:0] SCRUB = '1;
`ifdef CAM_ALLOC_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ins_valid = 1'b0;
    logic [DATA-1:0] ins_data = '0;
    logic            ins_ready;
    logic            rel_valid = 1'b0;
    logic [ADDR-1:0] rel_addr = '0;
    logic            we_;
    logic [DATA-1:0] wm;
    logic [DATA-1:0] wd;
    logic [ADDR-1:0] waddr;
    logic [ADDR-1:0] alloc_addr;
    logic [ADDR:0]   count;
    logic            full;
    logic            rel_err;

    always #5 clk = ~clk;

    cam_alloc dut (
        .clk        (clk),
        .reset      (reset),
        .ins_valid  (ins_valid),
        .ins_data   (ins_data),
        .ins_ready  (ins_ready),
        .rel_valid  (rel_valid),
        .rel_addr   (rel_addr),
        .we_        (we_),
        .wm         (wm),
        .wd         (wd),
        .waddr      (waddr),
        .alloc_addr (alloc_addr),
        .count      (count),
        .full       (full),
        .rel_err    (rel_err)
    );

    // Simple downstream CAM: captures the presented write at the next edge.
    logic [DATA-1:0] cam_mem [DEPTH];
    always @(posedge clk) begin
        if (we_ === 1'b0) cam_mem[waddr] <= wd;
    end

    function automatic int cam_lookup(input logic [DATA-1:0] key);
        for (int i = 0; i < DEPTH; i++) begin
            if (cam_mem[i] === key) return i;
        end
        return -1;
    endfunction

    // ---------------- scoreboard / reference model ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [ADDR+DATA-1:0] exp_q[$];

    bit              alloc_m [DEPTH];
    int              count_m;
    int              last_m;
    bit              rel_err_m;
    bit              exp_we;
    logic [ADDR-1:0] exp_waddr;
    logic [ADDR-1:0] exp_alloc;
    logic [DATA-1:0] exp_wd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) alloc_m[i] = 1'b0;
        count_m   = 0;
        last_m    = DEPTH - 1;
        rel_err_m = 1'b0;
        exp_we    = 1'b1;
        exp_waddr = '0;
        exp_alloc = '0;
        exp_wd    = '0;
        exp_q.delete();
    endfunction

    function automatic int pick_free();
        int start;
        start = RR ? (last_m + 1) % DEPTH : 0;
        for (int i = 0; i < DEPTH; i++) begin
            int e;
            e = (start + i) % DEPTH;
            if (!alloc_m[e]) return e;
        end
        return -1;
    endfunction

    function automatic void model_step(input bit iv, input logic [DATA-1:0] id,
                                       input bit rv, input logic [ADDR-1:0] ra);
        int e;
        exp_we = 1'b1;
        if (rv) begin
            if (alloc_m[ra]) begin
                alloc_m[ra] = 1'b0;
                count_m--;
                exp_we    = 1'b0;
                exp_waddr = ra;
                exp_wd    = SCRUB;
            end else begin
                rel_err_m = 1'b1;
            end
        end else if (iv && count_m < DEPTH) begin
            e = pick_free();
            alloc_m[e] = 1'b1;
            count_m++;
            exp_we    = 1'b0;
            exp_waddr = ADDR'(e);
            exp_wd    = id;
            exp_alloc = ADDR'(e);
            last_m    = e;
        end
        if (!exp_we) exp_q.push_back({exp_waddr, exp_wd});
    endfunction

    task automatic check_outputs();
        logic [ADDR+DATA-1:0] w;
        check("we_", 64'(we_), 64'(exp_we));
        if (we_ === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(waddr), 64'hdead);
            end else begin
                w = exp_q.pop_front();
                check("write_word", 64'({waddr, wd}), 64'(w));
            end
        end
        check("waddr", 64'(waddr), 64'(exp_waddr));
        check("wd", 64'(wd), 64'(exp_wd));
        check("alloc_addr", 64'(alloc_addr), 64'(exp_alloc));
        check("count", 64'(count), 64'(count_m));
        check("full", 64'(full), 64'(count_m == DEPTH));
        check("rel_err", 64'(rel_err), 64'(rel_err_m));
        check("wm", 64'(wm), 64'(0));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit iv, input logic [DATA-1:0] id,
                        input bit rv, input logic [ADDR-1:0] ra);
        @(negedge clk);
        ins_valid = iv;
        ins_data  = id;
        rel_valid = rv;
        rel_addr  = ra;
        #1;
        check("ins_ready", 64'(ins_ready), 64'((count_m < DEPTH) && !rv));
        model_step(iv, id, rv, ra);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input bit with_ins);
        @(negedge clk);
        reset     = 1'b1;
        ins_valid = with_ins;
        ins_data  = $urandom;
        rel_valid = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset     = 1'b0;
        ins_valid = 1'b0;
        #1;
        check("ins_ready_after_reset", 64'(ins_ready), 64'(1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        do_reset(1'b0);

        // Four inserts land in entries 0..3; 'h400 ends up in entry 2.
        for (int i = 0; i < 4; i++) step(1'b1, DATA'(32'h100 << i), 1'b0, '0);
        check("waddr_after_4", 64'(waddr), 64'(3));
        check("count_after_4", 64'(count), 64'(4));
        step(1'b0, '0, 1'b0, '0);
        check("cam_lookup_400", 64'(cam_lookup(32'h400)), 64'(2));

        // Fill to capacity, then an insert must stall.
        while (count_m < DEPTH) step(1'b1, $urandom, 1'b0, '0);
        check("full_when_filled", 64'(full), 64'(1));
        step(1'b1, $urandom, 1'b0, '0);
        check("stall_while_full", 64'(count), 64'(DEPTH));

        // Release entry 7 and reuse it.
        step(1'b0, '0, 1'b1, 5'd7);
        check("scrub_wd", 64'(wd), 64'(SCRUB));
        check("scrub_waddr", 64'(waddr), 64'(7));
        check("full_falls", 64'(full), 64'(0));
        step(1'b1, 32'hcafe_0007, 1'b0, '0);
        check("realloc_7", 64'(alloc_addr), 64'(7));

        // Insert and release together while full: release first, insert next.
        step(1'b1, 32'h1234_5678, 1'b1, 5'd3);
        check("release_wins", 64'(waddr), 64'(3));
        step(1'b1, 32'h1234_5678, 1'b0, '0);
        check("insert_into_3", 64'(alloc_addr), 64'(3));
        check("count_net_same", 64'(count), 64'(DEPTH));

        // Double release of entry 5.
        step(1'b0, '0, 1'b1, 5'd5);
        step(1'b0, '0, 1'b1, 5'd5);
        check("double_rel_no_write", 64'(we_), 64'(1));
        check("rel_err_set", 64'(rel_err), 64'(1));
        step(1'b0, '0, 1'b0, '0);
        check("rel_err_sticky", 64'(rel_err), 64'(1));

        // Allocate 0,1,2, release 0, insert: round-robin skips entry 0.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, '0);
        step(1'b0, '0, 1'b1, 5'd0);
        step(1'b1, 32'h0bad_f00d, 1'b0, '0);
        check("rr_or_lowest", 64'(alloc_addr), RR ? 64'(3) : 64'(0));

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) < 7, $urandom,
                 $urandom_range(0, 3) == 0, ADDR'($urandom_range(0, DEPTH - 1)));
        end

        // Reset landing on an insert-accept cycle squashes the write.
        do_reset(1'b0);
        step(1'b1, $urandom, 1'b0, '0);
        step(1'b1, $urandom, 1'b0, '0);
        do_reset(1'b1);
        check("reset_squash_we", 64'(we_), 64'(1));
        check("reset_count", 64'(count), 64'(0));
        check("reset_alloc", 64'(alloc_addr), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
